// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: display geometry,
// all-off codes and the active-low hex-to-segment table.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is hex digit 0.
    localparam logic [0:15][6:0] HEX_SEG = {
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return HEX_SEG[hex];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for an 8-digit common-anode display. The input word
// is captured once per frame so mid-scan changes never tear the display.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic        blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_VAL = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       digit;
    logic [31:0]      shadow;
    logic             load_pending;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;
    logic [7:0]       an_next;
    logic [6:0]       seg_next;

    assign slot_end  = (div_cnt == CNT_MAX);
    assign frame_end = slot_end && (digit == 3'(NUM_DIGITS - 1));
    assign nibble    = shadow[{digit, 2'b00} +: 4];

    hex7seg u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        if (!blank && (div_cnt >= DEAD_VAL)) begin
            an_next = ~(8'h01 << digit);
        end
        // Segments stay dark whenever no anode is driven, so blanking and
        // dead time never leave a stale pattern on the segment lines.
        if (an_next != AN_OFF) begin
            seg_next = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            digit   <= digit + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A post-reset load and a frame-boundary load on the same edge collapse
    // into one capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            load_pending <= 1'b1;
        end else begin
            if (load_pending || frame_end) begin
                shadow <= data;
            end
            load_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= 1'b1;
        end
    end

endmodule
